// File: rtl/tiny_io_scheduler.sv
// rtl/tiny_io_scheduler.sv - time-shares the user IO pads among NUM_DESIGNS tiny designs
// Wishbone-configured manual/round-robin selector with a hi-Z, all-in-reset guard between designs.
module tiny_io_scheduler #(
    parameter int          NUM_DESIGNS  = 4,
    parameter int          IO_W         = 38,
    parameter int          DWELL_W      = 16,
    parameter int          GUARD_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    input  logic [3:0]                  wbs_sel_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    input  logic [IO_W-1:0]             io_in,
    output logic [IO_W-1:0]             io_out,
    output logic [IO_W-1:0]             io_oeb,
    output logic [NUM_DESIGNS*IO_W-1:0] des_io_in,
    input  logic [NUM_DESIGNS*IO_W-1:0] des_io_out,
    input  logic [NUM_DESIGNS*IO_W-1:0] des_io_oeb,
    output logic [NUM_DESIGNS-1:0]      des_rst
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam int                 GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0]      GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [GW-1:0]      GUARD_ONE  = GW'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [3:0]         LAST_SEL   = 4'(NUM_DESIGNS - 1);
    localparam logic [4:0]         NUM_SEL    = 5'(NUM_DESIGNS);

    state_t             state_q, state_d;
    logic [GW-1:0]      guard_cnt_q, guard_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [3:0]         cur_sel_q, cur_sel_d;
    logic [3:0]         target_q, target_d;
    logic [15:0]        rot_cnt_q, rot_cnt_d;
    logic               en_q, auto_q;
    logic [3:0]         man_sel_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               ack_q;
    logic [31:0]        dat_o_q;
    logic [IO_W-1:0]    io_out_q, io_oeb_q;

    logic        wb_hit, wb_req, wb_ack_d;
    logic [1:0]  wb_off;
    logic [31:0] ctrl_word, dwell_word, status_word, rd_data, wr_base, wr_merge;
    logic [3:0]  man_target, auto_target;
    logic [IO_W-1:0] sel_out, sel_oeb;
    logic        unused_bits;

    assign wb_hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wb_off      = wbs_adr_i[3:2];
    assign wb_req      = wbs_cyc_i & wbs_stb_i & wb_hit;
    // Ack is blocked for one cycle after each ack so a held strobe never sees back-to-back acks.
    assign wb_ack_d    = wb_req & ~ack_q;
    assign ctrl_word   = {24'd0, man_sel_q, 2'b00, auto_q, en_q};
    assign dwell_word  = 32'(dwell_q);
    assign status_word = {rot_cnt_q, 8'd0, cur_sel_q, 2'b00, state_q};
    assign unused_bits = ^{wr_merge, wbs_adr_i[1:0]};

    always_comb begin
        rd_data = 32'd0;
        case (wb_off)
            2'd0:    rd_data = ctrl_word;
            2'd1:    rd_data = dwell_word;
            2'd2:    rd_data = status_word;
            default: rd_data = 32'd0;
        endcase
    end

    always_comb begin
        wr_base  = (wb_off == 2'd0) ? ctrl_word : dwell_word;
        wr_merge = wr_base;
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                wr_merge[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
            end
        end
    end

    assign man_target  = ({1'b0, man_sel_q} < NUM_SEL) ? man_sel_q : 4'd0;
    assign auto_target = (cur_sel_q == LAST_SEL) ? 4'd0 : cur_sel_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        cur_sel_d   = cur_sel_q;
        target_d    = target_q;
        rot_cnt_d   = rot_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = '0;
                    target_d    = auto_q ? 4'd0 : man_target;
                end
            end
            ST_GUARD: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (guard_cnt_q == GUARD_LAST) begin
                    state_d     = ST_ACTIVE;
                    cur_sel_d   = target_q;
                    rot_cnt_d   = rot_cnt_q + 16'd1;
                    dwell_cnt_d = '0;
                end else begin
                    guard_cnt_d = guard_cnt_q + GUARD_ONE;
                end
            end
            ST_ACTIVE: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (!auto_q && (man_target != cur_sel_q)) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = '0;
                    target_d    = man_target;
                end else if (auto_q && (dwell_q != '0) && (dwell_cnt_q == dwell_q - DWELL_ONE)) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = '0;
                    target_d    = auto_target;
                end else if (dwell_cnt_q != '1) begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_out = '0;
        sel_oeb = '1;
        for (int k = 0; k < NUM_DESIGNS; k++) begin
            if (cur_sel_q == 4'(k)) begin
                sel_out = des_io_out[k*IO_W +: IO_W];
                sel_oeb = des_io_oeb[k*IO_W +: IO_W];
            end
        end
    end

    always_comb begin
        des_io_in = '0;
        des_rst   = '1;
        if (state_q == ST_ACTIVE) begin
            for (int k = 0; k < NUM_DESIGNS; k++) begin
                if (cur_sel_q == 4'(k)) begin
                    des_io_in[k*IO_W +: IO_W] = io_in;
                    des_rst[k]                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            guard_cnt_q <= '0;
            dwell_cnt_q <= '0;
            cur_sel_q   <= 4'd0;
            target_q    <= 4'd0;
            rot_cnt_q   <= 16'd0;
            en_q        <= 1'b0;
            auto_q      <= 1'b0;
            man_sel_q   <= 4'd0;
            dwell_q     <= '0;
            ack_q       <= 1'b0;
            dat_o_q     <= 32'd0;
            io_out_q    <= '0;
            io_oeb_q    <= '1;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            cur_sel_q   <= cur_sel_d;
            target_q    <= target_d;
            rot_cnt_q   <= rot_cnt_d;
            ack_q       <= wb_ack_d;
            dat_o_q     <= wb_ack_d ? rd_data : 32'd0;
            if (wb_ack_d && wbs_we_i) begin
                case (wb_off)
                    2'd0: begin
                        en_q      <= wr_merge[0];
                        auto_q    <= wr_merge[1];
                        man_sel_q <= wr_merge[7:4];
                    end
                    2'd1:    dwell_q <= wr_merge[DWELL_W-1:0];
                    default: ;
                endcase
            end
            // Pads only carry a design while it stays active, so the whole guard window is hi-Z.
            if ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE)) begin
                io_out_q <= sel_out;
                io_oeb_q <= sel_oeb;
            end else begin
                io_out_q <= '0;
                io_oeb_q <= '1;
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign io_out    = io_out_q;
    assign io_oeb    = io_oeb_q;

endmodule

// File: tb/tb_tiny_io_scheduler.sv
// tb/tb_tiny_io_scheduler.sv - directed self-checking bench for tiny_io_scheduler
module tb_tiny_io_scheduler;

    localparam int          ND       = 4;
    localparam int          IO_W     = 38;
    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_DWELL  = 32'h3000_0004;
    localparam logic [31:0] A_STATUS = 32'h3000_0008;
    localparam logic [31:0] A_UNMAP  = 32'h3000_000C;
    localparam logic [31:0] A_MISS   = 32'h3000_0010;
    localparam logic [IO_W-1:0] ALL1 = '1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]       adr = 32'd0, dat_w = 32'd0;
    logic [3:0]        sel = 4'd0;
    logic              ack;
    logic [31:0]       dat_r;
    logic [IO_W-1:0]   io_in = 38'h2A_DEAD_BEEF;
    logic [IO_W-1:0]   io_out, io_oeb;
    logic [ND*IO_W-1:0] des_io_in, des_io_out, des_io_oeb;
    logic [ND-1:0]     des_rst;
    logic [IO_W-1:0]   d_out [ND];
    logic [IO_W-1:0]   d_oeb [ND];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < ND; k++) begin
            des_io_out[k*IO_W +: IO_W] = d_out[k];
            des_io_oeb[k*IO_W +: IO_W] = d_oeb[k];
        end
    end

    tiny_io_scheduler dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_sel_i  (sel),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .des_io_in  (des_io_in),
        .des_io_out (des_io_out),
        .des_io_oeb (des_io_oeb),
        .des_rst    (des_rst)
    );

    // Returns in the ack cycle, one time unit after the ack edge.
    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        int n;
        @(negedge clk);
        adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack !== 1'b1 && n < 8);
        rd = dat_r;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL wb_ack_timeout: addr %h no ack after %0d cycles", a, n);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (io_oeb !== ALL1 || io_out !== '0) begin
            bad++; $display("FAIL reset_pads: oeb=%h out=%h want oeb=all1 out=0", io_oeb, io_out);
        end
        total++;
        if (des_rst !== 4'b1111 || ack !== 1'b0 || dat_r !== 32'd0) begin
            bad++; $display("FAIL reset_misc: des_rst=%b ack=%b dat=%h want 1111 0 0", des_rst, ack, dat_r);
        end
        @(negedge clk) rst = 1'b0;
        wb_cycle(A_STATUS, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL reset_status: got %h want 0", rd); end
    endtask

    task automatic test_manual_enable;
        logic [31:0]        rd;
        logic [ND*IO_W-1:0] exp_in;
        wb_cycle(A_CTRL, 1'b1, 32'h21, 4'hF, rd);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (dut.state_q !== 2'd1 || io_oeb !== ALL1 || des_rst !== 4'hF) begin
                bad++; $display("FAIL enable_guard[%0d]: state=%0d oeb=%h rst=%b want 1 all1 1111", i, dut.state_q, io_oeb, des_rst);
            end
        end
        @(posedge clk); #1;
        total++;
        if (dut.state_q !== 2'd2 || dut.cur_sel_q !== 4'd2) begin
            bad++; $display("FAIL enable_active: state=%0d sel=%0d want 2 2", dut.state_q, dut.cur_sel_q);
        end
        total++;
        if (des_rst !== 4'b1011) begin bad++; $display("FAIL enable_des_rst: got %b want 1011", des_rst); end
        total++;
        if (io_oeb !== ALL1) begin bad++; $display("FAIL enable_first_cycle_hiz: oeb=%h want all1", io_oeb); end
        exp_in = '0;
        exp_in[2*IO_W +: IO_W] = io_in;
        total++;
        if (des_io_in !== exp_in) begin bad++; $display("FAIL enable_des_io_in: got %h want %h", des_io_in, exp_in); end
        @(posedge clk); #1;
        total++;
        if (io_out !== d_out[2] || io_oeb !== d_oeb[2]) begin
            bad++; $display("FAIL enable_pads: out=%h oeb=%h want %h %h", io_out, io_oeb, d_out[2], d_oeb[2]);
        end
        d_out[2] = 38'h3A_5A5A_5A5A;
        @(posedge clk); #1;
        total++;
        if (io_out !== 38'h3A_5A5A_5A5A) begin bad++; $display("FAIL pad_latency: got %h want 3a5a5a5a5a", io_out); end
        wb_cycle(A_STATUS, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'h0001_0022) begin bad++; $display("FAIL enable_status: got %h want 00010022", rd); end
    endtask

    task automatic test_manual_switch;
        logic [31:0] rd;
        logic [31:0] ctrl_tab [2] = '{32'h11, 32'h91};
        logic [3:0]  sel_tab  [2] = '{4'd1, 4'd0};
        logic [3:0]  rst_tab  [2] = '{4'b1101, 4'b1110};
        for (int s = 0; s < 2; s++) begin
            wb_cycle(A_CTRL, 1'b1, ctrl_tab[s], 4'hF, rd);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                total++;
                if (dut.state_q !== 2'd1 || io_oeb !== ALL1 || io_out !== '0) begin
                    bad++; $display("FAIL switch%0d_guard[%0d]: state=%0d oeb=%h out=%h want 1 all1 0", s, i, dut.state_q, io_oeb, io_out);
                end
            end
            @(posedge clk); #1;
            total++;
            if (dut.state_q !== 2'd2 || dut.cur_sel_q !== sel_tab[s] || des_rst !== rst_tab[s]) begin
                bad++; $display("FAIL switch%0d_active: state=%0d sel=%0d rst=%b want 2 %0d %b", s, dut.state_q, dut.cur_sel_q, des_rst, sel_tab[s], rst_tab[s]);
            end
        end
        wb_cycle(A_STATUS, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'h0003_0002) begin bad++; $display("FAIL switch_status: got %h want 00030002", rd); end
    endtask

    task automatic test_auto;
        logic [31:0] rd;
        int t, es, esel;
        logic [3:0] erst;
        wb_cycle(A_CTRL, 1'b1, 32'h00, 4'hF, rd);
        @(posedge clk); #1;
        total++;
        if (dut.state_q !== 2'd0) begin bad++; $display("FAIL auto_prep_idle: state=%0d want 0", dut.state_q); end
        wb_cycle(A_DWELL, 1'b1, 32'd10, 4'hF, rd);
        wb_cycle(A_CTRL, 1'b1, 32'h03, 4'hF, rd);
        for (int c = 1; c <= 66; c++) begin
            @(posedge clk); #1;
            es = 1; esel = 0;
            if (c > 4) begin
                t = c - 5;
                if ((t % 14) < 10) begin
                    es   = 2;
                    esel = (t / 14) % 4;
                end
            end
            erst = (es == 2) ? ~(4'b0001 << esel) : 4'b1111;
            total++;
            if (dut.state_q !== 2'(es) || des_rst !== erst || (es == 2 && dut.cur_sel_q !== 4'(esel))) begin
                bad++; $display("FAIL auto_cycle[%0d]: state=%0d sel=%0d rst=%b want %0d %0d %b", c, dut.state_q, dut.cur_sel_q, des_rst, es, esel, erst);
            end
        end
    endtask

    task automatic test_disable;
        logic [31:0] rd;
        wb_cycle(A_CTRL, 1'b1, 32'h00, 4'hF, rd);
        @(posedge clk); #1;
        total++;
        if (dut.state_q !== 2'd0 || io_oeb !== ALL1 || des_rst !== 4'hF) begin
            bad++; $display("FAIL disable_active: state=%0d oeb=%h rst=%b want 0 all1 1111", dut.state_q, io_oeb, des_rst);
        end
        wb_cycle(A_CTRL, 1'b1, 32'h01, 4'hF, rd);
        @(posedge clk); #1;
        wb_cycle(A_CTRL, 1'b1, 32'h00, 4'hF, rd);
        total++;
        if (dut.state_q !== 2'd1) begin bad++; $display("FAIL disable_in_guard: state=%0d want 1", dut.state_q); end
        @(posedge clk); #1;
        total++;
        if (dut.state_q !== 2'd0) begin bad++; $display("FAIL disable_guard_idle: state=%0d want 0", dut.state_q); end
        wb_cycle(A_STATUS, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'h0008_0000) begin bad++; $display("FAIL disable_status: got %h want 00080000", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        wb_cycle(A_CTRL, 1'b1, 32'h31, 4'hF, rd);
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (dut.cur_sel_q !== 4'd3 || io_out !== d_out[3] || io_oeb !== d_oeb[3]) begin
            bad++; $display("FAIL rstmid_pre: sel=%0d out=%h oeb=%h want 3 %h %h", dut.cur_sel_q, io_out, io_oeb, d_out[3], d_oeb[3]);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (dut.state_q !== 2'd0 || io_oeb !== ALL1 || io_out !== '0 || des_rst !== 4'hF || des_io_in !== '0) begin
            bad++; $display("FAIL rstmid_outputs: state=%0d oeb=%h out=%h rst=%b want 0 all1 0 1111", dut.state_q, io_oeb, io_out, des_rst);
        end
        @(negedge clk) rst = 1'b0;
        wb_cycle(A_CTRL, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL rstmid_ctrl: got %h want 0", rd); end
        wb_cycle(A_STATUS, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL rstmid_status: got %h want 0", rd); end
        wb_cycle(A_DWELL, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL rstmid_dwell: got %h want 0", rd); end
    endtask

    task automatic test_wishbone;
        logic [31:0] rd;
        logic        seen;
        wb_cycle(A_DWELL, 1'b1, 32'h0000_1234, 4'hF, rd);
        wb_cycle(A_DWELL, 1'b1, 32'hFFFF_FF56, 4'b0001, rd);
        wb_cycle(A_DWELL, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'h0000_1256) begin bad++; $display("FAIL lane_dwell: got %h want 00001256", rd); end
        wb_cycle(A_CTRL, 1'b1, 32'h0000_00F2, 4'hF, rd);
        wb_cycle(A_CTRL, 1'b1, 32'hABCD_EF50, 4'b0001, rd);
        wb_cycle(A_CTRL, 1'b1, 32'h0000_00FF, 4'b1110, rd);
        wb_cycle(A_CTRL, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'h0000_0050) begin bad++; $display("FAIL lane_ctrl: got %h want 00000050", rd); end
        wb_cycle(A_STATUS, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        wb_cycle(A_STATUS, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL status_ro: got %h want 0", rd); end
        wb_cycle(A_UNMAP, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        wb_cycle(A_UNMAP, 1'b0, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL unmapped_read: got %h want 0", rd); end
        @(posedge clk); #1;
        total++;
        if (ack !== 1'b0 || dat_r !== 32'd0) begin bad++; $display("FAIL ack_single: ack=%b dat=%h want 0 0", ack, dat_r); end
        @(negedge clk);
        adr = A_MISS; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL miss_no_ack: ack seen=%b want 0", seen); end
        adr = A_CTRL;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            total++;
            if (ack !== 1'(i % 2) || dat_r !== ((i % 2 == 1) ? 32'h50 : 32'd0)) begin
                bad++; $display("FAIL held_ack[%0d]: ack=%b dat=%h want %0d %h", i, ack, dat_r, i % 2, (i % 2 == 1) ? 32'h50 : 32'd0);
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        d_out[0] = 38'h01_1111_1111; d_oeb[0] = 38'h3F_FFFF_0000;
        d_out[1] = 38'h02_2222_2222; d_oeb[1] = 38'h3F_0000_FFFF;
        d_out[2] = 38'h03_3333_3333; d_oeb[2] = 38'h00_FF00_FF00;
        d_out[3] = 38'h04_4444_4444; d_oeb[3] = 38'h00_00FF_00FF;
        test_reset;
        test_manual_enable;
        test_manual_switch;
        test_auto;
        test_disable;
        test_reset_mid;
        test_wishbone;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
